// File: rtl/board_io.sv
// Board pin conditioner: reset synchroniser/stretcher, UART RX sync, PWM/heartbeat LEDs, debounced buttons.
// Latency: UART_RXD 2 edges, LED 1 edge, BTN 2+DEBOUNCE_CYCLES edges, BTN_PRESS one edge after BTN rises.
// Backpressure: none; every path is a free-running pipeline.
//
// Ports:
//   XCLK          board clock (only clock)
//   XRES          external reset, active-low, asynchronous assert
//   SOC_RES       active-high SoC reset, released synchronously after the stretch
//   UART_RXD_PIN  raw UART RX pin        -> UART_RXD  synchronised RX
//   LED_IN        per-LED on request
//   LED_BRIGHT    global PWM brightness  -> LED       LED pins (polarity per LED_ACTIVE_LOW)
//   BTN_PIN       raw buttons, high = pressed -> BTN (debounced level), BTN_PRESS (press pulse)
module board_io #(
  parameter int LED_WIDTH       = 16,
  parameter int LED_ACTIVE_LOW  = 0,
  parameter int BTN_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int RST_STRETCH     = 16,
  parameter int PWM_BITS        = 4,
  parameter int HB_DIV          = 24
) (
  input  logic                 XCLK,
  input  logic                 XRES,
  output logic                 SOC_RES,
  input  logic                 UART_RXD_PIN,
  output logic                 UART_RXD,
  input  logic [LED_WIDTH-1:0] LED_IN,
  input  logic [PWM_BITS-1:0]  LED_BRIGHT,
  output logic [LED_WIDTH-1:0] LED,
  input  logic [BTN_WIDTH-1:0] BTN_PIN,
  output logic [BTN_WIDTH-1:0] BTN,
  output logic [BTN_WIDTH-1:0] BTN_PRESS
);

  localparam int STR_W = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(RST_STRETCH - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LED_WIDTH-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? '1 : '0;

  // Reset path
  logic [1:0]       rst_sync_q, rst_sync_d;
  logic [STR_W-1:0] stretch_cnt_q, stretch_cnt_d;
  logic             soc_res_q, soc_res_d;

  // UART path
  logic [1:0]       uart_sync_q, uart_sync_d;

  // LED path
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [HB_DIV:0]      hb_cnt_q, hb_cnt_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [LED_WIDTH-1:0] lit;
  logic                 duty_on;

  // Button path
  logic [BTN_WIDTH-1:0]            btn_sync0_q, btn_sync1_q;
  logic [BTN_WIDTH-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [BTN_WIDTH-1:0]            btn_q, btn_d;
  logic [BTN_WIDTH-1:0]            btn_dly_q;
  logic [BTN_WIDTH-1:0]            press_q, press_d;

  // Reset release: two sync stages, then RST_STRETCH further edges; the
  // final edge of the count is the one that drops SOC_RES.
  always_comb begin
    rst_sync_d    = {rst_sync_q[0], 1'b1};
    stretch_cnt_d = stretch_cnt_q;
    soc_res_d     = soc_res_q;
    if (rst_sync_q[1] && soc_res_q) begin
      if (stretch_cnt_q == STR_LAST) begin
        soc_res_d = 1'b0;
      end else begin
        stretch_cnt_d = stretch_cnt_q + 1'b1;
      end
    end
  end

  assign uart_sync_d = {uart_sync_q[0], UART_RXD_PIN};

  // LEDs: heartbeat owns the pins while the SoC is in reset; otherwise the
  // SoC request is gated by PWM, with all-ones brightness meaning fully on.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    hb_cnt_d  = soc_res_q ? hb_cnt_q + 1'b1 : '0;
    duty_on   = (&LED_BRIGHT) || (pwm_cnt_q < LED_BRIGHT);
    lit       = '0;
    if (soc_res_q) begin
      lit[0] = hb_cnt_q[HB_DIV];
    end else if (duty_on) begin
      lit = LED_IN;
    end
    led_d = (LED_ACTIVE_LOW != 0) ? ~lit : lit;
  end

  // Debounce: a channel's counter only advances while the synchronised pin
  // disagrees with the accepted level; any agreement restarts the count.
  always_comb begin
    db_cnt_d = '0;
    btn_d    = btn_q;
    for (int i = 0; i < BTN_WIDTH; i++) begin
      if (btn_sync1_q[i] != btn_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          btn_d[i] = ~btn_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    // Rising edge of the accepted level, seen one edge after it happens.
    press_d = btn_q & ~btn_dly_q;
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      rst_sync_q    <= '0;
      stretch_cnt_q <= '0;
      soc_res_q     <= 1'b1;
      uart_sync_q   <= 2'b11;
      pwm_cnt_q     <= '0;
      hb_cnt_q      <= '0;
      led_q         <= LED_OFF;
      btn_sync0_q   <= '0;
      btn_sync1_q   <= '0;
      db_cnt_q      <= '0;
      btn_q         <= '0;
      btn_dly_q     <= '0;
      press_q       <= '0;
    end else begin
      rst_sync_q    <= rst_sync_d;
      stretch_cnt_q <= stretch_cnt_d;
      soc_res_q     <= soc_res_d;
      uart_sync_q   <= uart_sync_d;
      pwm_cnt_q     <= pwm_cnt_d;
      hb_cnt_q      <= hb_cnt_d;
      led_q         <= led_d;
      btn_sync0_q   <= BTN_PIN;
      btn_sync1_q   <= btn_sync0_q;
      db_cnt_q      <= db_cnt_d;
      btn_q         <= btn_d;
      btn_dly_q     <= btn_q;
      press_q       <= press_d;
    end
  end

  assign SOC_RES   = soc_res_q;
  assign UART_RXD  = uart_sync_q[1];
  assign LED       = led_q;
  assign BTN       = btn_q;
  assign BTN_PRESS = press_q;

endmodule

// File: doc/board_io.md
Name: board_io

Overview:
- Parametrised board-level I/O conditioner placed between the FPGA pins and the darksocv instance in each board top.
- Replaces direct pin-to-SoC wiring. Provides:
  - a synchronised, stretched SoC reset;
  - a metastability-safe UART RX input;
  - N-channel LED driving with SoC-controlled PWM dimming, configurable polarity, and a heartbeat while the SoC is held in reset;
  - M-channel debounced buttons with press pulses.

Parameters:
- LED_WIDTH, 16, number of LED outputs.
- LED_ACTIVE_LOW, 0, 1 = pins driven low to light.
- BTN_WIDTH, 4, number of button inputs.
- DEBOUNCE_CYCLES, 65536, consecutive stable cycles required to accept a button change (>=2).
- RST_STRETCH, 16, extra cycles SOC_RES is held after reset release (>=1).
- PWM_BITS, 4, brightness resolution.
- HB_DIV, 24, heartbeat half-period = 2^HB_DIV cycles.

Ports:
- XCLK  in  1  board clock; the only clock.
- XRES  in  1  external reset, asynchronous assert, active-low.
- SOC_RES  out  1  active-high reset to darksocv, synchronous deassert.
- UART_RXD_PIN  in  1  raw UART RX pin.
- UART_RXD  out  1  synchronised RX to SoC.
- LED_IN  in  LED_WIDTH  LED state requested by SoC.
- LED_BRIGHT  in  PWM_BITS  global LED brightness from SoC.
- LED  out  LED_WIDTH  LED pins.
- BTN_PIN  in  BTN_WIDTH  raw button pins, active-high pressed.
- BTN  out  BTN_WIDTH  debounced button level.
- BTN_PRESS  out  BTN_WIDTH  one-cycle pulse on debounced 0->1.

Behaviour:
- Reset state: XRES low clears every flop asynchronously. Resulting values:
  - SOC_RES=1; UART_RXD=1 (line idle);
  - LED = all inactive (0, or all-ones if LED_ACTIVE_LOW);
  - BTN=0; BTN_PRESS=0; all counters 0.
- Reset release:
  - XRES release passes through a 2-flop synchroniser, then a stretch counter.
  - SOC_RES falls on the (2+RST_STRETCH)th rising XCLK edge after XRES rises; the bench releases XRES mid-cycle.
  - XRES asserted again at any point, including mid-stretch, restarts the whole sequence with SOC_RES=1 immediately.
- UART: 2-flop synchroniser; UART_RXD follows UART_RXD_PIN with 2-edge latency.
- PWM:
  - pwm_cnt is a PWM_BITS free-running up-counter that wraps from all-ones to 0.
  - Duty: channel i lit = LED_IN[i] && (pwm_cnt < LED_BRIGHT), except LED_BRIGHT=all-ones, which means 100% on.
  - LED_BRIGHT=0 means always off.
- Heartbeat:
  - While SOC_RES=1, LED_IN and LED_BRIGHT are ignored. LED[0] toggles every 2^HB_DIV cycles, starting unlit; other LEDs are unlit.
  - The heartbeat counter runs only while SOC_RES=1 and clears when SOC_RES falls.
- LED output: registered, 1-cycle latency from LED_IN/LED_BRIGHT/pwm_cnt; inverted at the output register when LED_ACTIVE_LOW=1.
- Buttons: each channel has a 2-flop synchroniser and a debounce counter of width clog2(DEBOUNCE_CYCLES).
  - sync == BTN[i]: counter clears.
  - sync != BTN[i]: counter increments; when it reaches DEBOUNCE_CYCLES-1, BTN[i] toggles on the next edge and the counter clears.
  - Net latency from a clean pin edge to BTN change is 2+DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
  - BTN_PRESS[i] = 1 for exactly the cycle after BTN[i] goes 0->1; release produces no pulse.
  - Channels are independent; simultaneous presses on several channels give simultaneous pulses.
- Buttons and UART operate during SOC_RES=1 (the SoC ignores them); they are reset only by XRES.

Test Plan:
- Reset (RST_STRETCH=4):
  - XRES low, then release: SOC_RES stays 1 for 5 edges and falls on edge 6; LED all 0; UART_RXD=1 throughout.
  - Re-assert XRES 3 edges after release: SOC_RES stays 1, and a second release again needs 6 edges.
- Heartbeat (HB_DIV=3): hold SOC_RES high by a long stretch. LED[0] toggles every 8 cycles, 0 first; LED[15:1]=0; LED_IN=16'hFFFF has no effect.
- PWM (PWM_BITS=2, LED_IN=16'h0005, after reset):
  - LED_BRIGHT=1: bits 0,2 high 1 of every 4 cycles.
  - LED_BRIGHT=2: bits 0,2 high 2 of every 4 cycles.
  - LED_BRIGHT=3: bits 0,2 constant high; other bits constant 0.
  - LED_ACTIVE_LOW=1 variant: the exact complement.
- Debounce (DEBOUNCE_CYCLES=8):
  - BTN_PIN[1] 0->1 held: BTN[1] rises 10 edges later; BTN_PRESS[1] is a single 1-cycle pulse one edge after that.
  - A 5-cycle glitch: BTN and BTN_PRESS unchanged.
  - Release held 8+ cycles: BTN[1] falls with no pulse.
- Simultaneous: BTN_PIN=4'b1011 at the same edge produces identical timing on channels 0, 1 and 3; channel 2 stays 0.
- UART: toggle UART_RXD_PIN with random spacing >=1 cycle. UART_RXD equals the pin value delayed by exactly 2 edges.
